// File: rtl/joypad_event_pkg.sv
// Shared widths and event field positions for the joypad event queue.
// No logic; the event builder is a pure combinational helper.
// Consumers import this package with import joypad_event_pkg::*.
package joypad_event_pkg;

  localparam int BUTTON_W     = 12;
  localparam int EV_W         = 32;
  localparam int TS_W         = 16;
  localparam int TS_PRESCALE  = 1024;
  localparam int EV_PAD_BIT   = 31;
  localparam int EV_MASK_LSB  = 16;
  localparam int EV_STATE_LSB = 0;

  // Packs pad id, changed mask and new state; all other bits are zero.
  function automatic logic [EV_W-1:0] make_event(
    input logic                pad,
    input logic [BUTTON_W-1:0] mask,
    input logic [BUTTON_W-1:0] state
  );
    logic [EV_W-1:0] ev;
    ev = '0;
    ev[EV_PAD_BIT] = pad;
    ev[EV_MASK_LSB +: BUTTON_W] = mask;
    ev[EV_STATE_LSB +: BUTTON_W] = state;
    return ev;
  endfunction

endpackage

// File: rtl/joypad_debounce.sv
// Per-pad resync + stability filter; holds the last value handed to the queue.
// Latency: a steady input change raises pending STABLE_CYCLES+2 edges later.
// Backpressure: pending stays high, committed value frozen, until commit pulses.
module joypad_debounce
  import joypad_event_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                res,
  input  logic [BUTTON_W-1:0] pad_state,
  input  logic                commit,
  output logic                pending,
  output logic [BUTTON_W-1:0] cand,
  output logic [BUTTON_W-1:0] mask
);

  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [BUTTON_W-1:0] s1;
  logic [BUTTON_W-1:0] s2;
  logic [BUTTON_W-1:0] committed;
  logic [CW-1:0]       cnt;

  // Two-flop resync, then restart the stability count on any change of the sample.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      s1        <= '0;
      s2        <= '0;
      cand      <= '0;
      cnt       <= '0;
      committed <= '0;
    end else begin
      s1 <= pad_state;
      s2 <= s1;
      if (s2 != cand) begin
        cand <= s2;
        cnt  <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CW'(1);
      end
      // Committed tracks the true pad state even when the queue drops the event.
      if (commit) begin
        committed <= cand;
      end
    end
  end

  assign pending = (cnt == CNT_MAX) && (cand != committed);
  assign mask    = cand ^ committed;

endmodule

// File: rtl/joypad_event_queue.sv
// Debounces two joypads and queues change events for the CPU (show-ahead FIFO).
// Latency: steady change to ev_valid is STABLE_CYCLES+3 edges (+1 for pad 2 losing arbitration).
// Backpressure: a push into a full queue is dropped and sets sticky overflow. Option: JOYPAD_EVENT_TIMESTAMP_EN.
module joypad_event_queue
  import joypad_event_pkg::*;
#(
  parameter int DEPTH         = 16,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic [BUTTON_W-1:0]      joypad_1,
  input  logic [BUTTON_W-1:0]      joypad_2,
  output logic [EV_W-1:0]          ev_data,
  output logic                     ev_valid,
  input  logic                     ev_pop,
  output logic [$clog2(DEPTH):0]   ev_count,
  output logic                     overflow,
  input  logic                     overflow_clr
`ifdef JOYPAD_EVENT_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]          ev_time
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic                pend_1, pend_2;
  logic                commit_1, commit_2;
  logic [BUTTON_W-1:0] cand_1, cand_2;
  logic [BUTTON_W-1:0] mask_1, mask_2;

  logic [EV_W-1:0]     mem [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic                empty, full;
  logic                push_req, do_push, do_pop, drop;
  logic [EV_W-1:0]     push_ev;

  joypad_debounce #(.STABLE_CYCLES(STABLE_CYCLES)) u_pad_1 (
    .clk       (clk),
    .res       (res),
    .pad_state (joypad_1),
    .commit    (commit_1),
    .pending   (pend_1),
    .cand      (cand_1),
    .mask      (mask_1)
  );

  joypad_debounce #(.STABLE_CYCLES(STABLE_CYCLES)) u_pad_2 (
    .clk       (clk),
    .res       (res),
    .pad_state (joypad_2),
    .commit    (commit_2),
    .pending   (pend_2),
    .cand      (cand_2),
    .mask      (mask_2)
  );

  // Pad 1 wins; pad 2 keeps its committed value until it gets a free cycle.
  assign commit_1 = pend_1;
  assign commit_2 = pend_2 & ~pend_1;
  assign push_req = pend_1 | pend_2;
  assign push_ev  = pend_1 ? make_event(1'b0, mask_1, cand_1)
                           : make_event(1'b1, mask_2, cand_2);

  assign empty   = (ev_count == '0);
  assign full    = (ev_count == CW'(DEPTH));
  assign do_pop  = ev_pop & ~empty;
  // A pop frees the slot in the same cycle, so a full queue can still accept.
  assign do_push = push_req & (~full | do_pop);
  assign drop    = push_req & full & ~do_pop;

  // Event storage needs no reset; reads are gated by the count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_ev;
    end
  end

  // Pointers wrap naturally; the count is kept as its own register.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ev_count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      ev_count <= ev_count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

  assign ev_valid = ~empty;
  assign ev_data  = empty ? '0 : mem[rd_ptr];

`ifdef JOYPAD_EVENT_TIMESTAMP_EN
  localparam int PW = $clog2(TS_PRESCALE);
  localparam logic [PW-1:0] PRE_MAX = PW'(TS_PRESCALE - 1);

  logic [PW-1:0]   pre_cnt;
  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] ts_mem [DEPTH];

  // Coarse free-running time base: one tick per TS_PRESCALE clocks, wraps at all-ones.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      pre_cnt <= '0;
      ts_cnt  <= '0;
    end else if (pre_cnt == PRE_MAX) begin
      pre_cnt <= '0;
      ts_cnt  <= ts_cnt + TS_W'(1);
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end

  // Timestamp travels with its event in a parallel storage array.
  always_ff @(posedge clk) begin
    if (do_push) begin
      ts_mem[wr_ptr] <= ts_cnt;
    end
  end

  assign ev_time = empty ? '0 : ts_mem[rd_ptr];
`endif

endmodule

// File: tb/tb_joypad_event_queue.sv
// Directed bench for joypad_event_queue at DEPTH=16, STABLE_CYCLES=4.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Expected event words are built from hand-derived masks and states.
module tb_joypad_event_queue;

  logic        clk = 1'b0;
  logic        res;
  logic [11:0] joypad_1;
  logic [11:0] joypad_2;
  logic [31:0] ev_data;
  logic        ev_valid;
  logic        ev_pop;
  logic [4:0]  ev_count;
  logic        overflow;
  logic        overflow_clr;
`ifdef JOYPAD_EVENT_TIMESTAMP_EN
  logic [15:0] ev_time;
`endif

  int checks = 0;
  int errors = 0;

  joypad_event_queue #(.DEPTH(16), .STABLE_CYCLES(4)) dut (
    .clk          (clk),
    .res          (res),
    .joypad_1     (joypad_1),
    .joypad_2     (joypad_2),
    .ev_data      (ev_data),
    .ev_valid     (ev_valid),
    .ev_pop       (ev_pop),
    .ev_count     (ev_count),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
`ifdef JOYPAD_EVENT_TIMESTAMP_EN
    ,
    .ev_time      (ev_time)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_one();
    ev_pop = 1'b1;
    step();
    ev_pop = 1'b0;
  endtask

  task automatic do_reset();
    res = 1'b1;
    joypad_1 = '0;
    joypad_2 = '0;
    ev_pop = 1'b0;
    overflow_clr = 1'b0;
    step();
    step();
    res = 1'b0;
    step();
  endtask

  // Pushes 16 pad-1 events with states 1..16, each held until it is queued.
  task automatic fill_queue();
    for (int i = 0; i < 16; i++) begin
      joypad_1 = 12'(i + 1);
      repeat (7) step();
    end
  endtask

  task automatic test_reset();
    res = 1'b1;
    joypad_1 = '0;
    joypad_2 = '0;
    ev_pop = 1'b0;
    overflow_clr = 1'b0;
    step();
    checks++;
    if (ev_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ev_valid); end
    checks++;
    if (ev_count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", ev_count); end
    checks++;
    if (ev_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 00000000", ev_data); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    res = 1'b0;
    step();
  endtask

  task automatic test_single_event();
    do_reset();
    joypad_1 = 12'h001;
    repeat (6) step();
    checks++;
    if (ev_valid !== 1'b0) begin errors++; $display("FAIL single_early: valid got %b want 0 after 6 edges", ev_valid); end
    step();
    checks++;
    if (ev_valid !== 1'b1) begin errors++; $display("FAIL single_latency: valid got %b want 1 after 7 edges", ev_valid); end
    checks++;
    if (ev_data !== 32'h0001_0001) begin errors++; $display("FAIL single_data: got %h want 00010001", ev_data); end
    checks++;
    if (ev_count !== 5'd1) begin errors++; $display("FAIL single_count: got %0d want 1", ev_count); end
    pop_one();
    checks++;
    if (ev_valid !== 1'b0) begin errors++; $display("FAIL single_pop: valid got %b want 0", ev_valid); end
    pop_one();
    checks++;
    if (ev_count !== 5'd0) begin errors++; $display("FAIL empty_pop: count got %0d want 0", ev_count); end
  endtask

  task automatic test_glitch();
    do_reset();
    joypad_1 = 12'h010;
    step();
    step();
    joypad_1 = 12'h000;
    repeat (12) step();
    checks++;
    if (ev_count !== 5'd0) begin errors++; $display("FAIL glitch_count: got %0d want 0", ev_count); end
    checks++;
    if (ev_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid: got %b want 0", ev_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    joypad_1 = 12'h800;
    joypad_2 = 12'h800;
    repeat (7) step();
    checks++;
    if (ev_count !== 5'd1) begin errors++; $display("FAIL both_first_count: got %0d want 1", ev_count); end
    checks++;
    if (ev_data !== 32'h0800_0800) begin errors++; $display("FAIL both_first_data: got %h want 08000800", ev_data); end
    step();
    checks++;
    if (ev_count !== 5'd2) begin errors++; $display("FAIL both_second_count: got %0d want 2", ev_count); end
    checks++;
    if (ev_data !== 32'h0800_0800) begin errors++; $display("FAIL both_head_held: got %h want 08000800", ev_data); end
    pop_one();
    checks++;
    if (ev_data !== 32'h8800_0800) begin errors++; $display("FAIL both_second_data: got %h want 88000800", ev_data); end
    pop_one();
    checks++;
    if (ev_valid !== 1'b0) begin errors++; $display("FAIL both_drained: valid got %b want 0", ev_valid); end
  endtask

  task automatic test_release_mask();
    do_reset();
    joypad_1 = 12'h003;
    repeat (7) step();
    checks++;
    if (ev_data !== 32'h0003_0003) begin errors++; $display("FAIL press_data: got %h want 00030003", ev_data); end
    pop_one();
    joypad_1 = 12'h001;
    repeat (6) step();
    // Pop on an empty queue in the push cycle: ignored, push still lands.
    ev_pop = 1'b1;
    step();
    ev_pop = 1'b0;
    checks++;
    if (ev_count !== 5'd1) begin errors++; $display("FAIL empty_pop_push_count: got %0d want 1", ev_count); end
    checks++;
    if (ev_data !== 32'h0002_0001) begin errors++; $display("FAIL release_data: got %h want 00020001", ev_data); end
    pop_one();
  endtask

  task automatic test_overflow();
    logic [31:0] exp_q [16];
    logic [11:0] prev;
    do_reset();
    prev = 12'h000;
    for (int i = 0; i < 16; i++) begin
      exp_q[i] = {4'h0, prev ^ 12'(i + 1), 4'h0, 12'(i + 1)};
      prev = 12'(i + 1);
    end
    fill_queue();
    checks++;
    if (ev_count !== 5'd16) begin errors++; $display("FAIL fill_count: got %0d want 16", ev_count); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL fill_no_overflow: got %b want 0", overflow); end
    joypad_1 = 12'h0FF;
    repeat (7) step();
    checks++;
    if (ev_count !== 5'd16) begin errors++; $display("FAIL drop_count: got %0d want 16", ev_count); end
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL drop_overflow: got %b want 1", overflow); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (ev_data !== exp_q[i]) begin errors++; $display("FAIL order_%0d: got %h want %h", i, ev_data, exp_q[i]); end
      pop_one();
    end
    checks++;
    if (ev_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b want 0", ev_valid); end
    joypad_1 = 12'h000;
    repeat (7) step();
    checks++;
    if (ev_data !== 32'h00FF_0000) begin errors++; $display("FAIL true_state_mask: got %h want 00FF0000", ev_data); end
    pop_one();
    overflow_clr = 1'b1;
    step();
    overflow_clr = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_clr: got %b want 0", overflow); end
  endtask

  task automatic test_full_pop_push();
    do_reset();
    fill_queue();
    joypad_1 = 12'h100;
    repeat (6) step();
    ev_pop = 1'b1;
    step();
    ev_pop = 1'b0;
    checks++;
    if (ev_count !== 5'd16) begin errors++; $display("FAIL full_pop_push_count: got %0d want 16", ev_count); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL full_pop_push_overflow: got %b want 0", overflow); end
    checks++;
    if (ev_data !== 32'h0003_0002) begin errors++; $display("FAIL full_pop_push_head: got %h want 00030002", ev_data); end
    joypad_1 = 12'h200;
    repeat (7) step();
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL full_drop_overflow: got %b want 1", overflow); end
    repeat (15) pop_one();
    checks++;
    if (ev_count !== 5'd1) begin errors++; $display("FAIL tail_count: got %0d want 1", ev_count); end
    checks++;
    if (ev_data !== 32'h0110_0100) begin errors++; $display("FAIL tail_data: got %h want 01100100", ev_data); end
    // Reset between edges must clear state without waiting for a clock.
    #2;
    res = 1'b1;
    #1;
    checks++;
    if (ev_valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid: got %b want 0", ev_valid); end
    checks++;
    if (ev_count !== 5'd0) begin errors++; $display("FAIL async_reset_count: got %0d want 0", ev_count); end
    checks++;
    if (ev_data !== 32'h0) begin errors++; $display("FAIL async_reset_data: got %h want 00000000", ev_data); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL async_reset_overflow: got %b want 0", overflow); end
    step();
    res = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_event();
    test_glitch();
    test_back_to_back();
    test_release_mask();
    test_overflow();
    test_full_pop_push();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
